// File: rtl/mcu_subsys_bus.sv
// Single-master bus fabric: decodes host requests to ROM/RAM/PER slaves,
// with a per-transaction ready timeout and a sticky error log.
module mcu_subsys_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,
  output logic        rom_valid,
  output logic        ram_valid,
  output logic        per_valid,
  input  logic        rom_ready,
  input  logic        ram_ready,
  input  logic        per_ready,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] per_rdata,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  vld_q, vld_d;  // {per, ram, rom}; one-hot doubles as target select
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic        err_take;

  logic        hit_rom, hit_ram, hit_per, dec_err;
  logic        sel_rdy;
  logic [31:0] sel_rdata;

  always_comb begin
    hit_rom = (mem_addr[31:16] == 16'h0000);
    hit_ram = (mem_addr[31:16] == 16'h4000);
    hit_per = (mem_addr[31:8]  == 24'h80_0000);
    dec_err = !(hit_rom || hit_ram || hit_per) || (hit_rom && (mem_wstrb != 4'b0000));
  end

  // Only the selected slave can complete; other readys are masked out here.
  always_comb begin
    sel_rdy   = |(vld_q & {per_ready, ram_ready, rom_ready});
    sel_rdata = 32'h0;
    unique case (vld_q)
      3'b001:  sel_rdata = rom_rdata;
      3'b010:  sel_rdata = ram_rdata;
      3'b100:  sel_rdata = per_rdata;
      default: sel_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    eaddr_d  = eaddr_q;
    ecnt_d   = ecnt_q;
    err_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (dec_err) begin
            state_d  = ERR;
            rdata_d  = 32'h0;
            eaddr_d  = mem_addr;
            err_take = 1'b1;
          end else begin
            state_d = BUSY;
            vld_d   = {hit_per, hit_ram, hit_rom};
            cnt_d   = 16'h0;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
          end
        end
      end
      BUSY: begin
        if (sel_rdy) begin
          state_d = RESP;
          vld_d   = 3'b000;
          rdata_d = sel_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d  = ERR;
          vld_d    = 3'b000;
          rdata_d  = 32'h0;
          eaddr_d  = addr_q;
          err_take = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (err_take && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 3'b000;
      cnt_q   <= 16'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
      eaddr_q <= 32'h0;
      ecnt_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      eaddr_q <= eaddr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign mem_ready = (state_q == RESP) || (state_q == ERR);
  assign bus_err   = (state_q == ERR);
  assign mem_rdata = rdata_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_wstrb = wstrb_q;
  assign rom_valid = vld_q[0];
  assign ram_valid = vld_q[1];
  assign per_valid = vld_q[2];
  assign err_addr  = eaddr_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_mcu_subsys_bus.sv
// Bench for mcu_subsys_bus: a transaction-level timeline model predicts every
// cycle's outputs; a negedge process compares, plus literal pinning checks.
module tb_mcu_subsys_bus;
  localparam int TO   = 8;
  localparam int MAXC = 4096;

  logic        clk, rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata, slv_addr, slv_wdata;
  logic [3:0]  slv_wstrb;
  logic        rom_valid, ram_valid, per_valid;
  logic        rom_ready, ram_ready, per_ready;
  logic [31:0] rom_rdata, ram_rdata, per_rdata;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  mcu_subsys_bus #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .rom_valid(rom_valid), .ram_valid(ram_valid), .per_valid(per_valid),
    .rom_ready(rom_ready), .ram_ready(ram_ready), .per_ready(per_ready),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .per_rdata(per_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number (cycle n = time after posedge n).
  logic [2:0]  exp_vld [MAXC];
  bit          exp_rdy [MAXC];
  bit          exp_err [MAXC];
  logic [31:0] exp_rd  [MAXC];
  logic [31:0] exp_ea  [MAXC];
  logic [7:0]  exp_ec  [MAXC];
  logic [31:0] exp_sa  [MAXC];
  logic [31:0] exp_sw  [MAXC];
  logic [3:0]  exp_ss  [MAXC];

  int n_pass = 0, n_total = 0;
  int m_ecnt = 0;
  int req_cyc;
  int mon_ready_cnt, mon_err_cnt, mon_last_cyc;
  int mon_vcnt [3];
  logic [31:0] mon_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  always @(negedge clk) begin
    int n;
    n = cyc;
    if (mem_ready) begin
      mon_ready_cnt++;
      mon_last_cyc = n;
      mon_rdata = mem_rdata;
    end
    if (bus_err) mon_err_cnt++;
    if (rom_valid) mon_vcnt[0]++;
    if (ram_valid) mon_vcnt[1]++;
    if (per_valid) mon_vcnt[2]++;
    if (n < MAXC) begin
      chk($sformatf("ctrl@%0d", n),
          {27'd0, per_valid, ram_valid, rom_valid, mem_ready, bus_err},
          {27'd0, exp_vld[n], exp_rdy[n], exp_err[n]});
      if (exp_rdy[n]) chk($sformatf("rdata@%0d", n), mem_rdata, exp_rd[n]);
      if (exp_err[n]) begin
        chk($sformatf("err_addr@%0d", n), err_addr, exp_ea[n]);
        chk($sformatf("err_count@%0d", n), {24'd0, err_count}, {24'd0, exp_ec[n]});
      end
      if (exp_vld[n] != 3'b000) begin
        chk($sformatf("slv_addr@%0d", n), slv_addr, exp_sa[n]);
        chk($sformatf("slv_wdata@%0d", n), slv_wdata, exp_sw[n]);
        chk($sformatf("slv_wstrb@%0d", n), {28'd0, slv_wstrb}, {28'd0, exp_ss[n]});
      end
    end
  end

  function automatic int tgt_of(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h4000_0000 && a <= 32'h4000_FFFF) return 1;
    if (a >= 32'h8000_0000 && a <= 32'h8000_00FF) return 2;
    return 3;
  endfunction

  function automatic logic [2:0] rdy_vec(input int t, input int ok, input int d,
                                         input int c, input int r, input int now);
    logic [2:0] v;
    for (int s = 0; s < 3; s++)
      v[s] = (now == r) || ((s == t) ? (ok != 0 && now == c + 1 + d) : (now == c + 1));
    return v;
  endfunction

  // One host transaction; the target slave raises ready d cycles after its
  // valid rises (d<0: never). Non-target slaves and post-completion readys
  // are driven as noise the fabric must ignore.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] rd, input int d);
    int c, t, r, k, ok;
    bit derr;
    logic [2:0] rv;
    c = cyc;
    t = tgt_of(a);
    derr = (t == 3) || (t == 0 && ws != 4'h0);
    ok = (!derr && d >= 0 && d <= TO - 1) ? 1 : 0;
    req_cyc = c;
    if (derr) r = c + 1;
    else begin
      k = ok ? d : TO - 1;
      for (int i = 0; i <= k; i++) begin
        exp_vld[c+1+i] = 3'(1 << t);
        exp_sa[c+1+i] = a;
        exp_sw[c+1+i] = wd;
        exp_ss[c+1+i] = ws;
      end
      r = ok ? c + 2 + d : c + 1 + TO;
    end
    exp_rdy[r] = 1'b1;
    if (ok != 0) exp_rd[r] = rd;
    else begin
      exp_rd[r] = 32'h0;
      exp_err[r] = 1'b1;
      exp_ea[r] = a;
      if (m_ecnt < 255) m_ecnt++;
      exp_ec[r] = 8'(m_ecnt);
    end
    mon_ready_cnt = 0; mon_err_cnt = 0;
    for (int s = 0; s < 3; s++) mon_vcnt[s] = 0;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    rom_rdata = (t == 0) ? rd : ~rd;
    ram_rdata = (t == 1) ? rd : ~rd;
    per_rdata = (t == 2) ? rd : ~rd;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
    while (cyc <= r) begin
      rv = rdy_vec(t, ok, d, c, r, cyc);
      {per_ready, ram_ready, rom_ready} = rv;
      @(posedge clk); #1;
    end
    {per_ready, ram_ready, rom_ready} = 3'b000;
  endtask

  initial begin
    rst_n = 1'b1; mem_valid = 1'b0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    rom_ready = 0; ram_ready = 0; per_ready = 0;
    rom_rdata = 0; ram_rdata = 0; per_rdata = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {27'd0, per_valid, ram_valid, rom_valid, mem_ready, bus_err}, 32'd0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_errs", {err_count, 24'd0} | err_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ROM read: host sees mem_ready at the third edge after raising mem_valid.
    txn(32'h0000_0080, 32'h0, 4'h0, 32'h4001_0137, 0);
    chk("rom_latency", mon_last_cyc - req_cyc, 32'd2);
    chk("rom_rdata", mon_rdata, 32'h4001_0137);
    chk("rom_vcycles", mon_vcnt[0], 32'd1);
    chk("rom_pulses", mon_ready_cnt, 32'd1);

    // Readys while idle must not produce anything.
    {per_ready, ram_ready, rom_ready} = 3'b111;
    repeat (3) @(posedge clk);
    #1 {per_ready, ram_ready, rom_ready} = 3'b000;

    txn(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 5);
    chk("ram_vcycles", mon_vcnt[1], 32'd6);
    chk("ram_pulses", mon_ready_cnt, 32'd1);
    chk("ram_noerr", mon_err_cnt, 32'd0);

    // Unmapped: response one state after acceptance (third... second edge).
    txn(32'h2000_0000, 32'h0, 4'h0, 32'h1234_5678, 0);
    chk("unmap_latency", mon_last_cyc - req_cyc, 32'd1);
    chk("unmap_rdata", mon_rdata, 32'h0);
    chk("unmap_err_addr", err_addr, 32'h2000_0000);
    chk("unmap_err_count", {24'd0, err_count}, 32'd1);
    chk("unmap_novalid", mon_vcnt[0] + mon_vcnt[1] + mon_vcnt[2], 32'd0);

    txn(32'h8000_0004, 32'h0, 4'h0, 32'h9999_0000, -1);
    chk("to_vcycles", mon_vcnt[2], TO);
    chk("to_err", mon_err_cnt, 32'd1);
    chk("to_rdata", mon_rdata, 32'h0);
    chk("to_err_addr", err_addr, 32'h8000_0004);

    txn(32'h8000_0008, 32'h0, 4'h0, 32'h0BAD_F00D, TO - 1);
    chk("to_edge_noerr", mon_err_cnt, 32'd0);
    chk("to_edge_rdata", mon_rdata, 32'h0BAD_F00D);

    // Decode boundaries, back-to-back.
    txn(32'h0000_FFFC, 32'h0, 4'h0, 32'h1111_1111, 1);
    txn(32'h0001_0000, 32'h0, 4'h0, 32'h0, 0);
    txn(32'h4000_FFFC, 32'hCAFE_F00D, 4'h3, 32'h2222_2222, 2);
    txn(32'h8000_00FF, 32'h0, 4'h0, 32'h3333_3333, 0);
    txn(32'h8000_0100, 32'h0, 4'h0, 32'h0, 0);
    txn(32'h3FFF_FFFC, 32'h0, 4'h0, 32'h0, 0);
    txn(32'h8000_0010, 32'h0000_00A5, 4'h1, 32'h4444_4444, 3);

    txn(32'h0000_0090, 32'h0000_0077, 4'h1, 32'h0, 0);
    chk("romwr_novalid", mon_vcnt[0], 32'd0);
    chk("romwr_err", mon_err_cnt, 32'd1);
    for (int i = 0; i < 300; i++) txn(32'h0000_0090, 32'(i), 4'h1, 32'h0, 0);
    chk("err_saturate", {24'd0, err_count}, 32'd255);

    // Reset while BUSY on a RAM read.
    exp_vld[cyc+1] = 3'b010;
    exp_sa[cyc+1] = 32'h4000_0020; exp_sw[cyc+1] = 32'h0; exp_ss[cyc+1] = 4'h0;
    mem_valid = 1'b1; mem_addr = 32'h4000_0020; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    @(posedge clk); #1 mem_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    m_ecnt = 0;
    #1;
    chk("rst_ram_valid", {31'd0, ram_valid}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_slv_addr", slv_addr, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    @(posedge clk); #1 ram_ready = 1'b1;
    @(posedge clk); #1 ram_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    txn(32'h0000_0100, 32'h0, 4'h0, 32'h0013_0513, 0);
    chk("post_rst_pulses", mon_ready_cnt, 32'd1);
    chk("post_rst_rdata", mon_rdata, 32'h0013_0513);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
